pstage_buffer: RTL and testbench

Parametrised pipeline side-buffer that carries per-channel payloads, each with a valid bit, alongside the core pipeline stages. Each channel occupies its own contiguous stage window and obeys the core's per-stage stall and flush. On stall boundaries it inserts bubbles, and it reports retirement at each channel's last stage. It sits beside the F–W datapath and carries instruction metadata (PC, rd, exception info) without the main pipeline registers having to hold it.

---
 rtl/pstage_buffer_pkg.sv | 19 +
 rtl/pstage_slot.sv | 55 +++++
 rtl/pstage_buffer.sv | 123 ++++++++++++
 tb/tb_pstage_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pstage_buffer_pkg.sv
// Shared pipeline definitions used by the side-buffer and its slots.
//   stage_t  : core pipeline stage identifiers (F, D, E, M, W)
//   N_STAGES : number of core pipeline stages
//   word_t   : default payload word
package pstage_buffer_pkg;

  typedef enum logic [2:0] {
    F = 3'd0,
    D = 3'd1,
    E = 3'd2,
    M = 3'd3,
    W = 3'd4
  } stage_t;

  localparam int N_STAGES = 5;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/pstage_slot.sv
// One payload/valid slot of a side-buffer channel.
// Update priority at each edge: reset, flush, stall (hold), bubble when the
// upstream stage is stalled, otherwise load from the channel input (first
// slot of the window) or from the previous slot.
// Ports:
//   clk, grst        : clock, asynchronous active-low reset
//   flush, stall     : this stage's flush / stall
//   is_first         : slot is the first one of its channel window
//   upstream_stall   : stall of the stage feeding this one (0 for stage F)
//   ext_d, ext_dv    : channel input payload / valid (used when is_first)
//   d, dv            : previous slot payload / valid (used otherwise)
//   q, qv            : slot payload / valid
module pstage_slot
  import pstage_buffer_pkg::*;
#(
  parameter type T = word_t
) (
  input  logic clk,
  input  logic grst,
  input  logic flush,
  input  logic stall,
  input  logic is_first,
  input  logic upstream_stall,
  input  T     ext_d,
  input  logic ext_dv,
  input  T     d,
  input  logic dv,
  output T     q,
  output logic qv
);

  always_ff @(posedge clk or negedge grst) begin
    if (!grst) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (flush) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (stall) begin
      q  <= q;
      qv <= qv;
    end else if (upstream_stall) begin
      // Bubble carries a zero payload so stale data never trails a stall.
      q  <= '0;
      qv <= 1'b0;
    end else if (is_first) begin
      q  <= ext_d;
      qv <= ext_dv;
    end else begin
      q  <= d;
      qv <= dv;
    end
  end

endmodule

// File: rtl/pstage_buffer.sv
// Pipeline side-buffer: per-channel payload + valid carried through a
// contiguous window of core stages, following the core's stall and flush.
// Ports:
//   clk, grst    : clock, asynchronous active-low global reset
//   stall, flush : per-stage stall / flush from the core
//   entries_in   : per-channel payload entering at START[w]
//   valid_in     : per-channel valid for entries_in
//   entries      : slot payloads (0 outside the window)
//   valid        : slot valid bits (0 outside the window)
//   retire       : channel item leaves STOP[w] this cycle
//   retire_data  : payload held in STOP[w]
//   occupancy    : number of valid slots per channel
//   retired      : wrapping retire counter per channel
module pstage_buffer
  import pstage_buffer_pkg::*;
#(
  parameter int     Nitems        = 2,
  parameter type    T             = word_t,
  parameter stage_t START [Nitems] = '{F, F},
  parameter stage_t STOP  [Nitems] = '{W, W},
  parameter int     CNT_W         = 16
) (
  input  logic                            clk,
  input  logic                            grst,
  input  logic [N_STAGES-1:0]             stall,
  input  logic [N_STAGES-1:0]             flush,
  input  T                                entries_in  [Nitems],
  input  logic [Nitems-1:0]               valid_in,
  output T                                entries     [Nitems][N_STAGES],
  output logic                            valid       [Nitems][N_STAGES],
  output logic [Nitems-1:0]               retire,
  output T                                retire_data [Nitems],
  output logic [$clog2(N_STAGES+1)-1:0]   occupancy   [Nitems],
  output logic [CNT_W-1:0]                retired     [Nitems]
);

  localparam int OCC_W = $clog2(N_STAGES + 1);

  genvar gi, gj;

  generate
    for (gi = 0; gi < Nitems; gi++) begin : g_ch
      localparam int LO = int'(START[gi]);
      localparam int HI = int'(STOP[gi]);

      if (LO > HI || HI >= N_STAGES) begin : g_bad_window
        $error("pstage_buffer: channel %0d window %0d..%0d is invalid", gi, LO, HI);
      end

      for (gj = 0; gj < N_STAGES; gj++) begin : g_st
        if (gj >= LO && gj <= HI) begin : g_slot
          T     prev_d;
          logic prev_dv;
          logic up_stall;

          // The window head has no previous slot; it loads entries_in instead.
          if (gj == LO) begin : g_head
            assign prev_d  = '0;
            assign prev_dv = 1'b0;
          end else begin : g_body
            assign prev_d  = entries[gi][gj-1];
            assign prev_dv = valid[gi][gj-1];
          end

          // Stage F has no upstream stage, so it can never see a bubble.
          if (gj == 0) begin : g_no_up
            assign up_stall = 1'b0;
          end else begin : g_up
            assign up_stall = stall[gj-1];
          end

          pstage_slot #(
            .T(T)
          ) u_slot (
            .clk           (clk),
            .grst          (grst),
            .flush         (flush[gj]),
            .stall         (stall[gj]),
            .is_first      (gj == LO),
            .upstream_stall(up_stall),
            .ext_d         (entries_in[gi]),
            .ext_dv        (valid_in[gi]),
            .d             (prev_d),
            .dv            (prev_dv),
            .q             (entries[gi][gj]),
            .qv            (valid[gi][gj])
          );
        end else begin : g_empty
          assign entries[gi][gj] = '0;
          assign valid[gi][gj]   = 1'b0;
        end
      end

      // An item retires only when it actually moves out of the last stage.
      assign retire[gi]      = valid[gi][HI] & ~stall[HI] & ~flush[HI];
      assign retire_data[gi] = entries[gi][HI];

      logic [CNT_W-1:0] retired_reg;

      always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
          retired_reg <= '0;
        end else if (retire[gi]) begin
          retired_reg <= retired_reg + CNT_W'(1);
        end
      end

      assign retired[gi] = retired_reg;

      logic [OCC_W-1:0] occ_count;

      always_comb begin
        occ_count = '0;
        for (int j = LO; j <= HI; j++) begin
          occ_count = occ_count + OCC_W'(valid[gi][j]);
        end
      end

      assign occupancy[gi] = occ_count;
    end
  endgenerate

endmodule

// File: tb/tb_pstage_buffer.sv
// Self-checking bench for pstage_buffer: two channels with windows F..W and
// E..W and a 4-bit retire counter. Directed tables and sequences cover the
// latency, stall bubble, flush, retire suppression and counter wrap cases;
// a random phase is compared every cycle against a reference model.
module tb_pstage_buffer;
  import pstage_buffer_pkg::*;

  localparam int NI   = 2;
  localparam int CW   = 4;
  localparam int OW   = $clog2(N_STAGES + 1);
  localparam int ST [NI] = '{0, 2};
  localparam int SP [NI] = '{4, 4};
  localparam stage_t TB_START [NI] = '{F, E};
  localparam stage_t TB_STOP  [NI] = '{W, W};

  logic                clk = 1'b0;
  logic                grst;
  logic [N_STAGES-1:0] stall;
  logic [N_STAGES-1:0] flush;
  word_t               entries_in [NI];
  logic [NI-1:0]       valid_in;
  word_t               entries [NI][N_STAGES];
  logic                valid [NI][N_STAGES];
  logic [NI-1:0]       retire;
  word_t               retire_data [NI];
  logic [OW-1:0]       occupancy [NI];
  logic [CW-1:0]       retired [NI];

  pstage_buffer #(
    .Nitems(NI),
    .T     (word_t),
    .START (TB_START),
    .STOP  (TB_STOP),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .grst       (grst),
    .stall      (stall),
    .flush      (flush),
    .entries_in (entries_in),
    .valid_in   (valid_in),
    .entries    (entries),
    .valid      (valid),
    .retire     (retire),
    .retire_data(retire_data),
    .occupancy  (occupancy),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the buffer as a set of per-channel item arrays.
  logic  m_v [NI][N_STAGES];
  word_t m_d [NI][N_STAGES];
  int    m_cnt [NI];

  function automatic void model_reset();
    for (int w = 0; w < NI; w++) begin
      m_cnt[w] = 0;
      for (int i = 0; i < N_STAGES; i++) begin
        m_v[w][i] = 1'b0;
        m_d[w][i] = '0;
      end
    end
  endfunction

  // Advance the model by one clock edge using the inputs present now.
  function automatic void model_step();
    for (int w = 0; w < NI; w++) begin
      if (m_v[w][SP[w]] && !stall[SP[w]] && !flush[SP[w]])
        m_cnt[w] = (m_cnt[w] + 1) % (1 << CW);
      // Walk from the back so each stage still sees its predecessor's old item.
      for (int i = SP[w]; i >= ST[w]; i--) begin
        if (flush[i]) begin
          m_v[w][i] = 1'b0;
          m_d[w][i] = '0;
        end else if (stall[i]) begin
          // item stays put
        end else if (i > 0 && stall[i > 0 ? i - 1 : 0]) begin
          m_v[w][i] = 1'b0;
          m_d[w][i] = '0;
        end else if (i == ST[w]) begin
          m_v[w][i] = valid_in[w];
          m_d[w][i] = entries_in[w];
        end else begin
          m_v[w][i] = m_v[w][i-1];
          m_d[w][i] = m_d[w][i-1];
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_slot(input string name, input int w, input int i,
                          input logic v, input word_t d);
    chk({name, "_valid"}, 64'(valid[w][i]), 64'(v));
    chk({name, "_data"}, 64'(entries[w][i]), 64'(d));
  endtask

  task automatic check_model();
    int    occ;
    logic  exp_ret;
    for (int w = 0; w < NI; w++) begin
      occ = 0;
      for (int i = 0; i < N_STAGES; i++) begin
        chk($sformatf("valid[%0d][%0d]", w, i), 64'(valid[w][i]), 64'(m_v[w][i]));
        chk($sformatf("entries[%0d][%0d]", w, i), 64'(entries[w][i]), 64'(m_d[w][i]));
        occ += int'(m_v[w][i]);
      end
      exp_ret = m_v[w][SP[w]] && !stall[SP[w]] && !flush[SP[w]];
      chk($sformatf("retire[%0d]", w), 64'(retire[w]), 64'(exp_ret));
      chk($sformatf("retire_data[%0d]", w), 64'(retire_data[w]), 64'(m_d[w][SP[w]]));
      chk($sformatf("occupancy[%0d]", w), 64'(occupancy[w]), 64'(occ));
      chk($sformatf("retired[%0d]", w), 64'(retired[w]), 64'(m_cnt[w]));
    end
  endtask

  // Compare the current cycle with the model, then advance one edge.
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [N_STAGES-1:0] st, input logic [N_STAGES-1:0] fl,
                       input logic [NI-1:0] vi, input word_t d0, input word_t d1);
    stall         = st;
    flush         = fl;
    valid_in      = vi;
    entries_in[0] = d0;
    entries_in[1] = d1;
  endtask

  task automatic check_all_zero(input string name);
    for (int w = 0; w < NI; w++) begin
      for (int i = 0; i < N_STAGES; i++)
        chk_slot($sformatf("%s[%0d][%0d]", name, w, i), w, i, 1'b0, '0);
      chk($sformatf("%s_retired[%0d]", name, w), 64'(retired[w]), 64'd0);
      chk($sformatf("%s_occ[%0d]", name, w), 64'(occupancy[w]), 64'd0);
      chk($sformatf("%s_retire[%0d]", name, w), 64'(retire[w]), 64'd0);
    end
  endtask

  typedef struct {
    logic [NI-1:0] vi;
    word_t         din;
    logic [NI-1:0] exp_ret;
    word_t         exp_d0;
    word_t         exp_d1;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Free-flow table: inputs in cycles 0..9; channel 0 retires from cycle 5,
    // channel 1 (window starts at E) from cycle 3.
    for (int r = 0; r < 15; r++) begin
      tbl[r].vi      = (r < 10) ? 2'b11 : 2'b00;
      tbl[r].din     = (r < 10) ? word_t'(32'h100 + r) : '0;
      tbl[r].exp_ret = {1'(r >= 3 && r <= 12), 1'(r >= 5 && r <= 14)};
      tbl[r].exp_d0  = (r >= 5 && r <= 14) ? word_t'(32'h100 + r - 5) : '0;
      tbl[r].exp_d1  = (r >= 3 && r <= 12) ? word_t'(32'h100 + r - 3) : '0;
    end

    grst = 1'b0;
    drive('0, '0, '0, '0, '0);
    model_reset();
    #2;
    check_all_zero("in_reset");
    $display("reset asserted: outputs checked");
    @(posedge clk);
    #1;
    grst = 1'b1;
    tick();
    $display("reset released: first cycle checked");

    // ---------------- free flow ----------------
    for (int r = 0; r < 15; r++) begin
      drive('0, '0, tbl[r].vi, tbl[r].din, tbl[r].din);
      @(negedge clk);
      check_model();
      chk($sformatf("flow_retire_c%0d", r), 64'(retire), 64'(tbl[r].exp_ret));
      chk($sformatf("flow_rdata0_c%0d", r), 64'(retire_data[0]), 64'(tbl[r].exp_d0));
      chk($sformatf("flow_rdata1_c%0d", r), 64'(retire_data[1]), 64'(tbl[r].exp_d1));
      $display("flow cycle %0d: retire=%b rdata0=%h rdata1=%h", r, retire,
               retire_data[0], retire_data[1]);
      @(posedge clk);
      model_step();
      #1;
    end
    chk("flow_retired0", 64'(retired[0]), 64'd10);
    chk("flow_retired1", 64'(retired[1]), 64'd10);
    $display("free flow done: retired=%0d/%0d", retired[0], retired[1]);

    // ---------------- asynchronous reset mid-stream ----------------
    for (int k = 0; k < 6; k++) begin
      drive('0, '0, 2'b11, word_t'(32'h200 + k), word_t'(32'h300 + k));
      tick();
    end
    chk("midstream_occ0", 64'(occupancy[0]), 64'd5);
    chk("midstream_occ1", 64'(occupancy[1]), 64'd3);
    #2;
    grst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    $display("async reset mid-stream: outputs checked before next edge");
    @(posedge clk);
    #1;
    grst = 1'b1;
    drive('0, '0, '0, '0, '0);
    tick();

    // ---------------- stall bubble ----------------
    drive('0, '0, 2'b01, word_t'(32'hAA), '0);
    tick();
    drive('0, '0, '0, '0, '0);
    tick();
    chk_slot("pre_stall_D", 0, 1, 1'b1, word_t'(32'hAA));
    for (int k = 0; k < 2; k++) begin
      drive(5'b00010, '0, '0, '0, '0);
      tick();
      chk_slot($sformatf("stall%0d_D", k), 0, 1, 1'b1, word_t'(32'hAA));
      chk_slot($sformatf("stall%0d_E", k), 0, 2, 1'b0, '0);
      chk_slot($sformatf("stall%0d_E_ch1", k), 1, 2, 1'b0, '0);
    end
    drive('0, '0, '0, '0, '0);
    tick();
    chk_slot("release_E", 0, 2, 1'b1, word_t'(32'hAA));
    chk_slot("release_D", 0, 1, 1'b0, '0);
    $display("stall bubble sequence checked");
    for (int k = 0; k < 5; k++) tick();

    // ---------------- flush over stall ----------------
    drive('0, '0, 2'b01, word_t'(32'h55), '0);
    tick();
    drive('0, '0, '0, '0, '0);
    tick();
    tick();
    chk_slot("pre_flush_E", 0, 2, 1'b1, word_t'(32'h55));
    chk("pre_flush_occ0", 64'(occupancy[0]), 64'd1);
    drive(5'b00100, 5'b00100, '0, '0, '0);
    tick();
    chk_slot("flushed_E", 0, 2, 1'b0, '0);
    chk("flushed_occ0", 64'(occupancy[0]), 64'd0);
    drive('0, '0, '0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("flush_noret_%0d", k), 64'(retire[0]), 64'd0);
    end
    $display("flush over stall checked");

    // ---------------- retire suppression ----------------
    drive('0, '0, 2'b01, word_t'(32'h77), '0);
    tick();
    drive('0, '0, '0, '0, '0);
    for (int k = 0; k < 4; k++) tick();
    chk_slot("ret_W_loaded", 0, 4, 1'b1, word_t'(32'h77));
    drive(5'b10000, '0, '0, '0, '0);
    #1;
    chk("stalled_W_retire", 64'(retire[0]), 64'd0);
    tick();
    chk_slot("stalled_W_hold", 0, 4, 1'b1, word_t'(32'h77));
    drive('0, 5'b10000, '0, '0, '0);
    #1;
    chk("flushed_W_retire", 64'(retire[0]), 64'd0);
    tick();
    chk_slot("flushed_W", 0, 4, 1'b0, '0);
    drive('0, '0, '0, '0, '0);
    tick();
    $display("retire suppression checked");

    // ---------------- counter wrap ----------------
    #2;
    grst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    grst = 1'b1;
    tick();
    for (int r = 0; r < 25; r++) begin
      drive('0, '0, (r < 16) ? 2'b11 : 2'b00, (r < 16) ? word_t'(32'h400 + r) : '0,
            (r < 16) ? word_t'(32'h400 + r) : '0);
      #1;
      if (r == 18) begin
        chk("wrap_mid_retired0", 64'(retired[0]), 64'd13);
        chk("wrap_mid_retired1", 64'(retired[1]), 64'd15);
      end
      if (r == 24) begin
        chk("wrap_end_retired0", 64'(retired[0]), 64'd0);
        chk("wrap_end_retired1", 64'(retired[1]), 64'd0);
      end
      tick();
    end
    $display("counter wrap checked");

    // ---------------- random ----------------
    for (int k = 0; k < 400; k++) begin
      logic [N_STAGES-1:0] st;
      logic [N_STAGES-1:0] fl;
      for (int i = 0; i < N_STAGES; i++) begin
        st[i] = ($urandom_range(0, 99) < 15);
        fl[i] = ($urandom_range(0, 99) < 5);
      end
      drive(st, fl, NI'($urandom_range(0, 3)), word_t'($urandom), word_t'($urandom));
      tick();
    end
    drive('0, '0, '0, '0, '0);
    tick();
    $display("random phase done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
